// File: rtl/reg_file_mp_if.sv
// ============================================================================
// Module      : reg_file_mp_if
// Description : Write, read, and busy-scoreboard bus of the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [DATA_WIDTH-1:0]          IN;
    logic [ADDR_WIDTH-1:0]          INADDRESS;
    logic                           WRITE;
    logic [DATA_WIDTH/8-1:0]        WSTRB;
    logic [NUM_READ*ADDR_WIDTH-1:0] RADDR;
    logic [NUM_READ*DATA_WIDTH-1:0] RDATA;
    logic [NUM_READ-1:0]            RBUSY;
    logic                           BUSY_SET;
    logic [ADDR_WIDTH-1:0]          BUSY_ADDR;

    modport master (
        output IN, INADDRESS, WRITE, WSTRB, RADDR, BUSY_SET, BUSY_ADDR,
        input  RDATA, RBUSY
    );

    modport slave (
        input  IN, INADDRESS, WRITE, WSTRB, RADDR, BUSY_SET, BUSY_ADDR,
        output RDATA, RBUSY
    );
endinterface

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Byte-strobed register file with hardwired r0, write-first
//               bypass on every read port and a per-register busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  wire logic     CLK,
    input  wire logic     RESET,
    reg_file_mp_if.slave  bus
);
    localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;

    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic                  w_wr_en;
    logic                  w_set_en;

    assign w_wr_en  = bus.WRITE    && !RESET && (bus.INADDRESS != '0);
    assign w_set_en = bus.BUSY_SET && !RESET && (bus.BUSY_ADDR != '0);

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_mask
        assign w_mask[8*k +: 8] = {8{bus.WSTRB[k]}};
    end

    // Value the target register will hold after this edge; also the bypass value.
    assign w_merged = (r_regs[bus.INADDRESS] & ~w_mask) | (bus.IN & w_mask);

    // Set is applied after clear so a new issue outranks a retiring producer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_en) begin
            w_busy_nxt[bus.INADDRESS] = 1'b0;
        end
        if (w_set_en) begin
            w_busy_nxt[bus.BUSY_ADDR] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[bus.INADDRESS] <= w_merged;
            end
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic                  w_hit;

        assign w_raddr = bus.RADDR[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_hit   = w_wr_en && (bus.INADDRESS == w_raddr);

        assign bus.RDATA[p*DATA_WIDTH +: DATA_WIDTH] =
            (w_raddr == '0) ? '0 : (w_hit ? w_merged : r_regs[w_raddr]);

        // A retiring register is already readable through the bypass.
        assign bus.RBUSY[p] = (w_raddr != '0) && r_busy[w_raddr] && !w_hit;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Scoreboard bench for reg_file_mp against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NREG = 32;
    localparam int NB   = DW / 8;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

    reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]    rbusy;
    } exp_t;

    logic [DW-1:0] m_mem  [NREG];
    bit            m_busy [NREG];
    bit            m_valid = 1'b0;
    exp_t          sb_q [$];
    event          ev_chk;
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [NB-1:0] strb);
        logic [DW-1:0] res;
        for (int k = 0; k < NB; k++) begin
            res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; model state afterwards is the post-edge state.
    task automatic step(input logic rst, input logic wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [NB-1:0] ws,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic bs, input logic [AW-1:0] ba);
        exp_t e;
        logic [AW-1:0] a;
        @(negedge CLK);
        RESET         = rst;
        bus.WRITE     = wr;
        bus.INADDRESS = wa;
        bus.IN        = wd;
        bus.WSTRB     = ws;
        bus.RADDR     = {ra1, ra0};
        bus.BUSY_SET  = bs;
        bus.BUSY_ADDR = ba;
        for (int p = 0; p < NR; p++) begin
            a = (p == 0) ? ra0 : ra1;
            if (a == 0) begin
                e.rdata[p*DW +: DW] = '0;
                e.rbusy[p]          = 1'b0;
            end else if (!rst && wr && wa == a) begin
                e.rdata[p*DW +: DW] = merge(m_mem[a], wd, ws);
                e.rbusy[p]          = 1'b0;
            end else begin
                e.rdata[p*DW +: DW] = m_mem[a];
                e.rbusy[p]          = m_busy[a];
            end
        end
        if (m_valid) begin
            sb_q.push_back(e);
            -> ev_chk;
        end
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_valid = 1'b1;
        end else begin
            if (wr && wa != 0) begin
                m_mem[wa]  = merge(m_mem[wa], wd, ws);
                m_busy[wa] = 1'b0;
            end
            if (bs && ba != 0) m_busy[ba] = 1'b1;
        end
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        step(1'b0, 1'b0, '0, '0, '0, ra0, ra1, 1'b0, '0);
    endtask

    // Monitor: compares every presented read result against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(ev_chk);
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rdata0", {32'd0, bus.RDATA[DW-1:0]},  {32'd0, e.rdata[DW-1:0]});
                check("rdata1", {32'd0, bus.RDATA[2*DW-1:DW]}, {32'd0, e.rdata[2*DW-1:DW]});
                check("rbusy",  {62'd0, bus.RBUSY}, {62'd0, e.rbusy});
            end
        end
    end

    initial begin
        RESET = 1'b1;
        bus.WRITE = 1'b0; bus.INADDRESS = '0; bus.IN = '0; bus.WSTRB = '0;
        bus.RADDR = '0; bus.BUSY_SET = 1'b0; bus.BUSY_ADDR = '0;

        step(1'b1, 1'b0, '0, '0, '0, 5'd0, 5'd0, 1'b0, '0);

        // Reset discards a concurrent write and clears prior state.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd7, 1'b1, 5'd7);
        step(1'b1, 1'b1, 5'd7, 32'h11, 4'hF, 5'd5, 5'd7, 1'b0, '0);
        idle(5'd5, 5'd7);
        #3;
        check("reset_r5", {32'd0, bus.RDATA[31:0]}, 64'd0);
        check("reset_r7", {32'd0, bus.RDATA[63:32]}, 64'd0);
        check("reset_busy", {62'd0, bus.RBUSY}, 64'd0);

        // Full write with bypass.
        step(1'b0, 1'b1, 5'd3, 32'h5F, 4'hF, 5'd3, 5'd0, 1'b0, '0);
        #3 check("bypass_full", {32'd0, bus.RDATA[31:0]}, 64'h5F);
        idle(5'd3, 5'd3);
        #3 check("hold_full", {32'd0, bus.RDATA[31:0]}, 64'h5F);

        // Byte strobes.
        step(1'b0, 1'b1, 5'd4, 32'h11223344, 4'hF, 5'd0, 5'd0, 1'b0, '0);
        step(1'b0, 1'b1, 5'd4, 32'hAABBCCDD, 4'b0101, 5'd4, 5'd4, 1'b0, '0);
        #3 check("bypass_strb", {32'd0, bus.RDATA[63:32]}, 64'h11BB33DD);
        idle(5'd4, 5'd4);
        #3 check("post_strb", {32'd0, bus.RDATA[31:0]}, 64'h11BB33DD);

        // Register 0.
        step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 1'b1, 5'd0);
        #3 check("r0_data", {bus.RDATA}, 64'd0);
        idle(5'd0, 5'd0);
        #3 check("r0_busy", {62'd0, bus.RBUSY}, 64'd0);

        // Scoreboard set, hold and clear on writeback.
        step(1'b0, 1'b0, '0, '0, '0, 5'd9, 5'd9, 1'b1, 5'd9);
        idle(5'd9, 5'd9);
        #3 check("busy_set", {62'd0, bus.RBUSY}, 64'd3);
        idle(5'd9, 5'd9);
        step(1'b0, 1'b1, 5'd9, 32'h42, 4'hF, 5'd9, 5'd9, 1'b0, '0);
        #3 check("retire_busy", {62'd0, bus.RBUSY}, 64'd0);
        check("retire_data", {32'd0, bus.RDATA[31:0]}, 64'h42);
        idle(5'd9, 5'd9);

        // Set/clear collisions.
        step(1'b0, 1'b0, '0, '0, '0, 5'd9, 5'd10, 1'b1, 5'd9);
        step(1'b0, 1'b1, 5'd9, 32'h7, 4'hF, 5'd9, 5'd10, 1'b1, 5'd9);
        idle(5'd9, 5'd10);
        #3 check("collide_set_wins", {62'd0, bus.RBUSY}, 64'd1);
        step(1'b0, 1'b1, 5'd9, 32'h8, 4'hF, 5'd9, 5'd10, 1'b1, 5'd10);
        idle(5'd9, 5'd10);
        #3 check("collide_diff", {62'd0, bus.RBUSY}, 64'd2);

        // Randomized traffic over a narrow address window to force collisions.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 6),
                 5'($urandom_range(0, int'(lim))),
                 32'($urandom()),
                 4'($urandom_range(0, 15)),
                 5'($urandom_range(0, int'(lim))),
                 5'($urandom_range(0, int'(lim))),
                 ($urandom_range(0, 9) < 4),
                 5'($urandom_range(0, int'(lim))));
        end

        @(negedge CLK);
        #5;
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
